// File: rtl/imem_loader.sv
// imem_loader
//   Loads a program image from a host byte stream into the byte-wide write
//   port of the big-endian instruction memory. A load zero-clears the whole
//   memory first. It then takes a 4-byte big-endian length header and writes
//   the payload bytes in stream order. The core is held in reset for the
//   whole load.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   start        request a new load (sampled only in IDLE)
//   in_valid     host byte valid
//   in_data      host byte
//   in_ready     loader accepts a byte (transfer = in_valid && in_ready)
//   mem_we       registered byte write enable
//   mem_addr     registered byte address (0 when mem_we is 0)
//   mem_wdata    registered byte data (0 when mem_we is 0)
//   cpu_hold     core reset hold, equal to busy
//   busy         high in every state except IDLE
//   done         one-cycle pulse after a load completes
//   err_len      sticky: header length exceeded MEM_SIZE
//   bytes_loaded payload bytes written by the last or current load
module imem_loader #(
    parameter int unsigned MEM_SIZE  = 4095,
    parameter logic [63:0] BASE_ADDR = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err_len,
    output logic [31:0] bytes_loaded
);

    localparam logic [31:0] MEM_LEN  = 32'(MEM_SIZE);
    localparam logic [31:0] LAST_IDX = MEM_LEN - 32'd1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        HDR,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    state_t      state_q, state_d;

    // idx is the clear counter k in CLEAR and the stream index n in LOAD/DRAIN.
    logic [31:0] idx_q, idx_d;
    logic [31:0] len_q, len_d;
    logic [31:0] eff_q, eff_d;
    logic [1:0]  hdr_cnt_q, hdr_cnt_d;
    logic        err_q, err_d;
    logic [31:0] bytes_q, bytes_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        done_q, done_d;

    logic        accept;
    logic [31:0] hdr_full;

    assign in_ready = (state_q == HDR) || (state_q == LOAD) || (state_q == DRAIN);
    assign accept   = in_valid && in_ready;
    // Header value after shifting in the current byte, MSB first.
    assign hdr_full = {len_q[23:0], in_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            eff_q     <= '0;
            hdr_cnt_q <= '0;
            err_q     <= 1'b0;
            bytes_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            eff_q     <= eff_d;
            hdr_cnt_q <= hdr_cnt_d;
            err_q     <= err_d;
            bytes_q   <= bytes_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        eff_d     = eff_q;
        hdr_cnt_d = hdr_cnt_q;
        err_d     = err_q;
        bytes_d   = bytes_q;
        we_d      = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    bytes_d = '0;
                end
            end

            CLEAR: begin
                we_d   = 1'b1;
                addr_d = BASE_ADDR + {32'd0, idx_q};
                if (idx_q == LAST_IDX) begin
                    state_d   = HDR;
                    idx_d     = '0;
                    hdr_cnt_d = '0;
                end else begin
                    idx_d = idx_q + 32'd1;
                end
            end

            HDR: begin
                if (accept) begin
                    len_d     = hdr_full;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        idx_d = '0;
                        if (hdr_full > MEM_LEN) begin
                            eff_d = MEM_LEN;
                            err_d = 1'b1;
                        end else begin
                            eff_d = hdr_full;
                        end
                        state_d = (hdr_full == 32'd0) ? DONE : LOAD;
                    end
                end
            end

            LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + {32'd0, idx_q};
                    wdata_d = in_data;
                    bytes_d = bytes_q + 32'd1;
                    idx_d   = idx_q + 32'd1;
                    if (idx_q == eff_q - 32'd1)
                        state_d = (len_q > eff_q) ? DRAIN : DONE;
                end
            end

            DRAIN: begin
                // idx keeps counting stream bytes so the drain ends at len-1.
                if (accept) begin
                    idx_d = idx_q + 32'd1;
                    if (idx_q == len_q - 32'd1)
                        state_d = DONE;
                end
            end

            DONE: begin
                // The final write (if any) is visible in this cycle; done is
                // registered so it appears one cycle later, together with IDLE.
                state_d = IDLE;
                done_d  = 1'b1;
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign cpu_hold     = busy;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign done         = done_q;
    assign err_len      = err_q;
    assign bytes_loaded = bytes_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with MEM_SIZE=16. Stimulus tasks push the
// expected writes (address, data, cycle) and done-pulse cycles into queues;
// a negedge monitor pops and compares whenever the DUT shows a write or done.
module tb_imem_loader;

    localparam int MSIZE = 16;

    typedef struct {
        longint     addr;
        logic [7:0] data;
        int         due;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err_len;
    logic [31:0] bytes_loaded;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    wr_t        wq[$];
    int         dq[$];
    logic [7:0] pl[$];
    logic [7:0] img [0:MSIZE-1];

    imem_loader #(.MEM_SIZE(MSIZE), .BASE_ADDR(64'd0)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .busy(busy), .done(done), .err_len(err_len), .bytes_loaded(bytes_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT write and done pulse against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", mem_addr, 64'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_addr", mem_addr, e.addr);
                    check("wr_data", mem_wdata, e.data);
                    check("wr_cycle", cyc, e.due);
                    if (mem_addr < 64'(MSIZE)) img[mem_addr[3:0]] = mem_wdata;
                end
            end else begin
                check("idle_addr_data", {mem_addr, mem_wdata}, 0);
            end
            check("hold_eq_busy", cpu_hold, busy);
            if (done) begin
                check("done_no_write", mem_we, 0);
                check("done_not_busy", busy, 0);
                if (dq.size() == 0) check("unexpected_done", cyc, -1);
                else check("done_cycle", cyc, dq.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit wr, input int addr, output int hs);
        int t = 0;
        hs = -1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            hs = cyc;
            if (wr) wq.push_back('{addr: longint'(addr), data: d, due: cyc + 1});
        end
    endtask

    // One full load: clear, header, payload from pl. abort_after >= 0 asserts
    // reset after that many payload bytes instead of finishing.
    task automatic run_load(input logic [31:0] len, input int gap,
                            input int abort_after, input bit mid_start);
        int c0, hs, t;
        logic [31:0] eff;
        eff = (len > 32'(MSIZE)) ? 32'(MSIZE) : len;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        for (int k = 0; k < MSIZE; k++)
            wq.push_back('{addr: longint'(k), data: 8'h00, due: c0 + 2 + k});
        for (int i = 1; i <= MSIZE; i++) begin
            @(negedge clk);
            start = (mid_start && i == 5);
            check("clear_in_ready", in_ready, 0);
            check("clear_busy", busy, 1);
            check("clear_hold", cpu_hold, 1);
            if (i == 1) begin
                check("start_clr_err", err_len, 0);
                check("start_clr_bytes", bytes_loaded, 0);
            end
        end
        @(negedge clk);
        check("hdr_in_ready", in_ready, 1);
        for (int b = 3; b >= 0; b--) begin
            logic [31:0] tmp;
            tmp = len >> (8 * b);
            send_byte(tmp[7:0], 1'b0, 0, hs);
        end
        for (int i = 0; i < pl.size(); i++) begin
            if (abort_after >= 0 && i == abort_after) break;
            send_byte(pl[i], (32'(i) < eff), i, hs);
            repeat (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
        end
        if (abort_after >= 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            check("abort_outputs",
                  {mem_we, mem_addr, mem_wdata, in_ready, cpu_hold, busy, done, err_len, bytes_loaded},
                  0);
            reset = 1'b0;
            repeat (8) @(negedge clk);
            check("abort_queues", wq.size() + dq.size(), 0);
        end else begin
            dq.push_back(hs + 2);
            @(negedge clk);
            in_valid = 1'b0;
            t = 0;
            while ((wq.size() != 0 || dq.size() != 0) && t < 50) begin
                @(negedge clk);
                t++;
            end
            check("load_complete", wq.size() + dq.size(), 0);
            @(negedge clk);
            check("bytes_loaded", bytes_loaded, eff);
            check("err_len", err_len, len > 32'(MSIZE));
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        int hs;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {mem_we, mem_addr, mem_wdata, in_ready, cpu_hold, busy, done, err_len, bytes_loaded},
              0);
        reset = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Tests 1+2: clear (with an ignored start mid-clear) and an 8-byte program.
        pl = '{8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h00, 8'h01, 8'h13};
        run_load(32'd8, 0, -1, 1'b1);
        check("fetch_addr0", {img[0], img[1], img[2], img[3]}, 32'h0050_0093);
        check("fetch_addr4", {img[4], img[5], img[6], img[7]}, 32'h0000_0113);

        // Test 3: oversize header, 16 writes then 4 drained bytes.
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'(i * 7 + 3));
        run_load(32'd20, 0, -1, 1'b0);

        // Test 4: empty image.
        pl.delete();
        run_load(32'd0, 0, -1, 1'b0);

        // Test 5: payload with two idle cycles after every byte.
        pl.delete();
        for (int i = 0; i < 6; i++) pl.push_back(8'hA0 + 8'(i));
        run_load(32'd6, 2, -1, 1'b0);

        // Test 6: reset after 3 payload bytes.
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'h30 + 8'(i));
        run_load(32'd8, 0, 3, 1'b0);

        // Recovery after abort: full-size exact load.
        pl.delete();
        for (int i = 0; i < 16; i++) pl.push_back(8'hF0 - 8'(i));
        run_load(32'd16, 0, -1, 1'b0);

        repeat (5) @(negedge clk);
        check("final_queues", wq.size() + dq.size(), 0);
        hs = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the byte-addressed, big-endian instruction memory. Receives a program image as a byte stream from a host link (UART/debug bridge) and writes it into the instruction memory's write port.
- Before loading, zero-clears the whole memory, then writes the image byte by byte. Holds the core in reset until the load completes.
- Sits between the host byte receiver and the instruction memory. The core's fetch path is otherwise unchanged.

Parameters:
- MEM_SIZE, 4095, number of bytes in the instruction memory; addresses BASE_ADDR..BASE_ADDR+MEM_SIZE-1.
- BASE_ADDR, 0, byte address of the first memory location written.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new load; sampled only in IDLE.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts byte; a transfer occurs when in_valid && in_ready.
- mem_we  output  1  instruction memory byte write enable.
- mem_addr  output  64  byte write address.
- mem_wdata  output  8  byte write data.
- cpu_hold  output  1  holds the core in reset while a load is in progress.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a load completes.
- err_len  output  1  sticky; header length exceeded MEM_SIZE. Cleared on start.
- bytes_loaded  output  32  bytes written in the last or current load. Cleared on start.

Behaviour:
- Reset: state IDLE; all outputs 0; internal counters and length register 0. Reset mid-operation aborts immediately: no further writes, no done pulse, and memory keeps partial contents.
- mem_we, mem_addr and mem_wdata are registered. mem_addr and mem_wdata are 0 whenever mem_we is 0.
- cpu_hold equals busy.
- States: IDLE, CLEAR, HDR, LOAD, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> CLEAR; clears err_len, bytes_loaded and the clear counter k.
  - start is ignored in all other states.
- CLEAR:
  - in_ready=0.
  - One write per cycle: mem_we=1, mem_addr=BASE_ADDR+k, mem_wdata=0, for k=0..MEM_SIZE-1. Exactly MEM_SIZE writes.
  - After the write of k=MEM_SIZE-1 is issued -> HDR.
- HDR:
  - in_ready=1.
  - Accepts 4 bytes and forms len[31:0] big-endian (first byte is bits 31:24).
  - After the 4th byte, compute eff_len = min(len, MEM_SIZE). If len>MEM_SIZE, set err_len.
  - len==0 -> DONE; otherwise -> LOAD with write counter n=0.
- LOAD:
  - in_ready=1.
  - Each accepted byte produces, on the next cycle, mem_we=1, mem_addr=BASE_ADDR+n, mem_wdata=byte. Then n and bytes_loaded increment.
  - Write latency is exactly 1 cycle from the handshake. Back-to-back bytes produce back-to-back writes.
  - No write occurs for cycles with in_valid=0.
  - On acceptance of byte n=eff_len-1: -> DRAIN if len>eff_len, else -> DONE.
- DRAIN:
  - in_ready=1.
  - Accepts and discards len-eff_len bytes with no writes, then -> DONE.
- DONE:
  - in_ready=0.
  - The pending final write, if any, completes in this state.
  - done=1 is asserted in the cycle after the last mem_we. It is never asserted in the same cycle as a write.
  - Then -> IDLE: busy and cpu_hold drop with the done pulse.
- Byte order: stream byte i lands at BASE_ADDR+i. A 32-bit instruction must be sent MSB first so that the big-endian fetch {mem[a],mem[a+1],mem[a+2],mem[a+3]} returns it.
- Width rules:
  - len is 32-bit unsigned.
  - The comparison with MEM_SIZE is unsigned.
  - mem_addr is the zero-extended 64-bit sum BASE_ADDR+n and never wraps within MEM_SIZE.
- in_valid is ignored whenever in_ready=0; bytes offered then are not consumed.

Test Plan:
1. MEM_SIZE=16: reset 3 cycles -> all outputs 0, state IDLE. Pulse start -> 16 consecutive mem_we with addr 0..15, data 0; in_ready=0 throughout; cpu_hold=1.
2. After clear, send header 00 00 00 08, then bytes 00 50 00 93 00 00 01 13 back-to-back -> writes at addr 0..7 with those bytes, each 1 cycle after its handshake; done pulse 1 cycle after the last write; bytes_loaded=8; a fetch at addr 0 returns 0x00500093 and at addr 4 returns 0x00000113.
3. Header 00 00 00 14 (20) with MEM_SIZE=16 -> err_len=1; 16 writes at addr 0..15; 4 further bytes accepted with no mem_we; done pulses; bytes_loaded=16.
4. Header 00 00 00 00 -> no payload writes; done pulses 1 cycle after entering DONE; bytes_loaded=0.
5. Payload with in_valid toggling 1,0,0,1,... -> mem_we only on cycles following handshakes; addresses contiguous with no gaps.
6. Assert reset after 3 payload bytes -> next cycle all outputs 0 and no done pulse. start while busy -> ignored: no restart, clear counter unaffected.
